// File: rtl/lzy_jk_bank_ctrl.sv
// Command sequencer for a bank of falling-edge JK flip-flops.
// Valid/ready: a command transfers on a rising Clk edge where Cmd_valid and
// Cmd_ready are both high; Cmd_ready is high only in IDLE, and Cmd_valid
// offered in any other state is ignored (nothing is latched).
// J/K are computed from the latched op and a registered copy of Q_fb (Qr),
// so they are stable across the whole controller cycle and are sampled by
// the bank on the falling edge in the middle of that cycle.
module lzy_jk_bank_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Rd,
   input  logic             Cmd_valid,
   output logic             Cmd_ready,
   input  logic [2:0]       Cmd_op,
   input  logic [WIDTH-1:0] Cmd_data,
   input  logic [CNT_W-1:0] Cmd_len,
   input  logic [WIDTH-1:0] Q_fb,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   output logic             Clr_n,
   output logic             Busy,
   output logic             Done,
   output logic             Err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_HOLD  = 3'd0;
   localparam logic [2:0] OP_LOAD  = 3'd1;
   localparam logic [2:0] OP_UP    = 3'd2;
   localparam logic [2:0] OP_DOWN  = 3'd3;
   localparam logic [2:0] OP_SHL   = 3'd4;
   localparam logic [2:0] OP_SHR   = 3'd5;
   localparam logic [2:0] OP_CLEAR = 3'd6;
   localparam logic [2:0] OP_RSVD  = 3'd7;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             sin_q, sin_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] qr_q;

   logic             multi_cycle;
   logic [CNT_W-1:0] len_eff;
   logic [WIDTH-1:0] t_up, t_dn, shl_next, shr_next;
   logic             run_clear;

   // Ops that honour Cmd_len; a length of zero is promoted to one cycle.
   assign multi_cycle = (Cmd_op == OP_HOLD) || (Cmd_op == OP_UP) || (Cmd_op == OP_DOWN) ||
                        (Cmd_op == OP_SHL)  || (Cmd_op == OP_SHR);
   assign len_eff     = (Cmd_len == '0) ? CNT_ONE : Cmd_len;

   assign shl_next = {qr_q[WIDTH-2:0], sin_q};
   assign shr_next = {sin_q, qr_q[WIDTH-1:1]};

   // Toggle enables for the counters: bit i toggles when all lower bits are 1 (up) or 0 (down).
   always_comb begin
      t_up[0] = 1'b1;
      t_dn[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         t_up[i] = t_up[i-1] & qr_q[i-1];
         t_dn[i] = t_dn[i-1] & ~qr_q[i-1];
      end
   end

   // State, command latches, cycle counter and the Q feedback register.
   always_ff @(posedge Clk or posedge Rd) begin
      if (Rd) begin
         state_q <= IDLE;
         op_q    <= 3'd0;
         data_q  <= '0;
         sin_q   <= 1'b0;
         rem_q   <= '0;
         qr_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         sin_q   <= sin_d;
         rem_q   <= rem_d;
         qr_q    <= Q_fb;
      end
   end

   // Next state: accept in IDLE, count down in RUN, single-cycle DONE.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      data_d  = data_q;
      sin_d   = sin_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE: begin
            if (Cmd_valid) begin
               op_d    = Cmd_op;
               data_d  = Cmd_data;
               sin_d   = Cmd_data[0];
               rem_d   = multi_cycle ? len_eff : CNT_ONE;
               state_d = RUN;
            end
         end
         RUN: begin
            rem_d = rem_q - CNT_ONE;
            if (rem_q == CNT_ONE) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs: handshake/status per state, J/K drive only while running.
   always_comb begin
      Cmd_ready = 1'b0;
      Busy      = 1'b0;
      Done      = 1'b0;
      Err       = 1'b0;
      J         = '0;
      K         = '0;
      run_clear = 1'b0;
      case (state_q)
         IDLE: begin
            Cmd_ready = 1'b1;
         end
         RUN: begin
            Busy = 1'b1;
            case (op_q)
               OP_LOAD: begin
                  J = data_q;
                  K = ~data_q;
               end
               OP_UP: begin
                  J = t_up;
                  K = t_up;
               end
               OP_DOWN: begin
                  J = t_dn;
                  K = t_dn;
               end
               OP_SHL: begin
                  J = shl_next;
                  K = ~shl_next;
               end
               OP_SHR: begin
                  J = shr_next;
                  K = ~shr_next;
               end
               OP_CLEAR: begin
                  run_clear = 1'b1;
               end
               default: begin
               end
            endcase
         end
         DONE: begin
            Busy = 1'b1;
            Done = 1'b1;
            Err  = (op_q == OP_RSVD);
         end
         default: begin
         end
      endcase
   end

   // The bank is held clear during reset and for the one RUN cycle of CLEAR.
   assign Clr_n = ~Rd & ~run_clear;

endmodule

// File: tb/tb_lzy_jk_bank_ctrl.sv
// Bench for lzy_jk_bank_ctrl: a 4-cell falling-edge JK bank model closes the
// Q_fb loop; expected bank values come from plain arithmetic per op.
module tb_lzy_jk_bank_ctrl;

   logic       Clk;
   logic       Rd;
   logic       Cmd_valid;
   logic       Cmd_ready;
   logic [2:0] Cmd_op;
   logic [3:0] Cmd_data;
   logic [7:0] Cmd_len;
   logic [3:0] Q_fb;
   logic [3:0] J;
   logic [3:0] K;
   logic       Clr_n;
   logic       Busy;
   logic       Done;
   logic       Err;

   int n_checks = 0;
   int n_errs   = 0;
   logic [3:0] model_q;
   logic [3:0] bank_q;

   lzy_jk_bank_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
      .Clk       (Clk),
      .Rd        (Rd),
      .Cmd_valid (Cmd_valid),
      .Cmd_ready (Cmd_ready),
      .Cmd_op    (Cmd_op),
      .Cmd_data  (Cmd_data),
      .Cmd_len   (Cmd_len),
      .Q_fb      (Q_fb),
      .J         (J),
      .K         (K),
      .Clr_n     (Clr_n),
      .Busy      (Busy),
      .Done      (Done),
      .Err       (Err)
   );

   // Clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Bank of four falling-edge JK cells with asynchronous active-low clear.
   always @(negedge Clk or negedge Clr_n) begin
      logic [3:0] nq;
      nq = bank_q;
      if (!Clr_n) begin
         bank_q <= 4'b0000;
      end else begin
         for (int i = 0; i < 4; i++) begin
            case ({J[i], K[i]})
               2'b01:   nq[i] = 1'b0;
               2'b10:   nq[i] = 1'b1;
               2'b11:   nq[i] = ~bank_q[i];
               default: nq[i] = bank_q[i];
            endcase
         end
         bank_q <= nq;
      end
   end
   assign Q_fb = bank_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: bank value after one active cycle of the given op.
   function automatic logic [3:0] ref_step(input logic [2:0] op, input logic [3:0] q,
                                           input logic sin, input logic [3:0] data);
      case (op)
         3'd1:    return data;
         3'd2:    return 4'((q + 1) % 16);
         3'd3:    return 4'((q + 15) % 16);
         3'd4:    return 4'(((q * 2) + sin) % 16);
         3'd5:    return 4'((sin * 8) + (q / 2));
         3'd6:    return 4'd0;
         default: return q;
      endcase
   endfunction

   // Driver: issue one command, follow it through RUN and DONE, check every cycle.
   // With poke set, junk commands are offered while busy and must be ignored.
   task automatic do_cmd(input logic [2:0] op, input logic [3:0] data, input logic [7:0] len,
                         input bit poke);
      int n;
      logic [3:0] q_exp;
      n = (op == 3'd1 || op == 3'd6 || op == 3'd7) ? 1 : ((len == 8'd0) ? 1 : int'(len));
      q_exp = model_q;
      check("ready_before_cmd", Cmd_ready, 1);
      Cmd_op    = op;
      Cmd_data  = data;
      Cmd_len   = len;
      Cmd_valid = 1'b1;
      @(posedge Clk); #1;
      Cmd_valid = 1'b0;
      check("ready_in_run", Cmd_ready, 0);
      check("busy_in_run", Busy, 1);
      check("clr_n_in_run", Clr_n, (op == 3'd6) ? 0 : 1);
      for (int c = 1; c <= n; c++) begin
         if (poke) begin
            Cmd_valid = 1'($urandom_range(0, 1));
            Cmd_op    = 3'($urandom_range(0, 7));
            Cmd_data  = 4'($urandom_range(0, 15));
            Cmd_len   = 8'($urandom_range(0, 255));
         end
         @(posedge Clk); #1;
         q_exp = ref_step(op, q_exp, data[0], data);
         check("q_step", Q_fb, q_exp);
         check("done_timing", Done, (c == n) ? 1 : 0);
         check("err_timing", Err, (c == n && op == 3'd7) ? 1 : 0);
      end
      Cmd_valid = 1'b0;
      @(posedge Clk); #1;
      check("ready_after_done", Cmd_ready, 1);
      check("busy_after_done", Busy, 0);
      check("done_single_pulse", Done, 0);
      check("q_after_done", Q_fb, q_exp);
      model_q = q_exp;
   endtask

   initial begin
      Rd        = 1'b1;
      Cmd_valid = 1'b0;
      Cmd_op    = 3'd0;
      Cmd_data  = 4'd0;
      Cmd_len   = 8'd0;
      repeat (2) @(posedge Clk);
      #1;
      check("rst_ready", Cmd_ready, 1);
      check("rst_j", J, 0);
      check("rst_k", K, 0);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_err", Err, 0);
      check("rst_clr_n", Clr_n, 0);
      check("rst_q", Q_fb, 0);
      @(negedge Clk); #1;
      Rd = 1'b0;
      #1;
      check("rel_clr_n", Clr_n, 1);
      @(posedge Clk); #1;
      model_q = 4'b0000;

      // Directed sequences
      do_cmd(3'd1, 4'b1010, 8'd0, 1'b0);
      do_cmd(3'd1, 4'b1101, 8'd0, 1'b0);
      do_cmd(3'd2, 4'b0000, 8'd5, 1'b0);
      do_cmd(3'd1, 4'b0001, 8'd0, 1'b0);
      do_cmd(3'd3, 4'b0000, 8'd3, 1'b0);
      do_cmd(3'd1, 4'b0110, 8'd0, 1'b0);
      do_cmd(3'd4, 4'b0001, 8'd2, 1'b0);
      do_cmd(3'd5, 4'b0000, 8'd1, 1'b0);
      do_cmd(3'd6, 4'b1111, 8'd9, 1'b0);
      do_cmd(3'd2, 4'b0000, 8'd0, 1'b0);
      do_cmd(3'd7, 4'b1111, 8'd4, 1'b0);
      do_cmd(3'd6, 4'b0000, 8'd0, 1'b0);

      // Abort: UP len=10, reset during the 4th RUN cycle
      Cmd_op    = 3'd2;
      Cmd_data  = 4'd0;
      Cmd_len   = 8'd10;
      Cmd_valid = 1'b1;
      @(posedge Clk); #1;
      Cmd_valid = 1'b0;
      repeat (3) begin
         @(posedge Clk); #1;
      end
      check("abort_q_before", Q_fb, 3);
      Rd = 1'b1;
      #1;
      check("abort_q_cleared", Q_fb, 0);
      check("abort_clr_n", Clr_n, 0);
      check("abort_ready", Cmd_ready, 1);
      check("abort_busy", Busy, 0);
      check("abort_done", Done, 0);
      @(negedge Clk); #1;
      Rd = 1'b0;
      repeat (3) begin
         @(posedge Clk); #1;
         check("abort_no_done", Done, 0);
         check("abort_ready_after", Cmd_ready, 1);
         check("abort_q_held", Q_fb, 0);
      end
      model_q = 4'b0000;
      do_cmd(3'd1, 4'b0011, 8'd0, 1'b0);

      // Longest command length
      do_cmd(3'd2, 4'b0000, 8'd255, 1'b1);

      // Randomized commands
      repeat (30) begin
         do_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                8'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
